rr_arbiter_4: RTL and testbench
===============================

RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

Interface
REQ-001 Parameter: HOLD_MAX, default 8, maximum consecutive cycles one grant may be held; legal range 1..15.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: ena  input  1  arbiter enable; 0 blocks new grants and forces release of the current one.
REQ-005 Port: req  input  4  per-requester request lines; bit i = requester i.
REQ-006 Port: done  input  1  current grant holder signals completion.
REQ-007 Port: grant  output  4  one-hot grant, registered; all zero when no grant.
REQ-008 Port: grant_id  output  2  binary index of the current holder; valid only while valid=1.
REQ-009 Port: valid  output  1  registered; 1 while a grant is held.

Function
REQ-010 The block SHALL implement a two-state FSM with states IDLE and BUSY.
REQ-011 The block SHALL keep a 2-bit priority pointer ptr (reset 0) and a 4-bit tenure counter cnt (reset 0).
REQ-012 In IDLE with ena=1 and req!=0, the block SHALL select the first set req bit searching ptr, ptr+1, ... mod 4, and at the next edge enter BUSY with valid=1, grant_id=selected index, cnt=0.
REQ-013 Grant latency SHALL be exactly one cycle: req sampled at edge N gives grant visible after edge N.
REQ-014 In IDLE with ena=0 or req=0, the block SHALL remain in IDLE with grant=0, valid=0.
REQ-015 grant SHALL always equal the one-hot decode of grant_id when valid=1 and 4'b0000 when valid=0; it SHALL never have more than one bit set.
REQ-016 In BUSY, grant and grant_id SHALL be stable; cnt SHALL increment by 1 each cycle without releasing.
REQ-017 In BUSY, a release SHALL occur at the edge where any of these is sampled: done=1; req[grant_id]=0; ena=0; cnt==HOLD_MAX-1.
REQ-018 On release, the block SHALL enter IDLE with valid=0, grant=0, cnt=0, and ptr=grant_id+1 mod 4 (3 wraps to 0).
REQ-019 Multiple simultaneous release causes SHALL produce one release, with ptr advanced by exactly one position.
REQ-020 After a release, at least one IDLE cycle with grant=0 SHALL occur before the next grant.
REQ-021 With HOLD_MAX=1, each grant SHALL last exactly one cycle.
REQ-022 Changes to req bits other than req[grant_id] during BUSY SHALL have no effect until the next IDLE arbitration.
REQ-023 grant_id SHALL retain its last value while valid=0.

Reset
REQ-024 While rst=1, the block SHALL immediately, independent of clk, force state=IDLE, grant=0, grant_id=0, valid=0, ptr=0, cnt=0.
REQ-025 A reset asserted during BUSY SHALL drop grant asynchronously, with no release-side pointer update.
REQ-026 After rst deasserts, the first grant SHALL be possible at the second rising edge: one edge enters arbitration, the next presents the grant.

Verification
REQ-027 Reset then ena=1, req=4'b1010 -> one cycle later grant=4'b0010, grant_id=1, valid=1; done pulse -> grant=0, ptr=2; next arbitration grants 4'b1000.
REQ-028 Fairness: req=4'b1111 held, done pulsed each grant, ena=1 -> grant sequence 0001, 0010, 0100, 1000, 0001, each separated by one idle cycle.
REQ-029 Timeout: HOLD_MAX=8, req=4'b0100 held, done=0 -> grant=4'b0100 for exactly 8 cycles, 1 idle cycle, then re-grant 4'b0100 (only requester).
REQ-030 Requester drop: grant=4'b0001 held, req[0] deasserts while req[3]=1 -> release next edge; after the idle cycle grant=4'b1000.
REQ-031 ena=0 during BUSY -> release at next edge; with ena=0 held, no grant is issued despite req=4'b1111.
REQ-032 Asynchronous reset mid-BUSY (grant=4'b0100) between clock edges -> grant=0, valid=0 immediately; after deassert, req=4'b0110 grants 4'b0010 (ptr=0).

Source files
------------

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a bounded grant tenure.
// One grant is held at a time. A release always costs one idle cycle, and the
// priority pointer then moves to the slot after the previous holder.
module rr_arbiter_4 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       valid
);

  typedef enum logic {StIdle, StBusy} state_e;

  localparam logic [3:0] CntLast = 4'(HOLD_MAX - 1);

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] gid_q, gid_d;
  logic [3:0] grant_q, grant_d;
  logic       valid_q, valid_d;
  // Cleared by reset; the first edge after reset only arms arbitration.
  logic       armed_q, armed_d;

  logic [1:0] sel;
  logic [1:0] idx;
  logic       found;
  logic       release_now;

  // Rotating priority search starting at ptr_q.
  always_comb begin
    sel   = ptr_q;
    idx   = ptr_q;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // Any release cause ends the tenure; simultaneous causes collapse into one.
  always_comb begin
    release_now = done | ~req[gid_q] | ~ena | (cnt_q == CntLast);
  end

  // Next-state logic for the FSM, pointer, tenure counter and outputs.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gid_d   = gid_q;
    grant_d = grant_q;
    valid_d = valid_q;
    armed_d = 1'b1;
    unique case (state_q)
      StIdle: begin
        grant_d = 4'b0000;
        valid_d = 1'b0;
        cnt_d   = 4'd0;
        if (armed_q && ena && found) begin
          state_d = StBusy;
          gid_d   = sel;
          grant_d = 4'b0001 << sel;
          valid_d = 1'b1;
        end
      end
      StBusy: begin
        if (release_now) begin
          state_d = StIdle;
          grant_d = 4'b0000;
          valid_d = 1'b0;
          cnt_d   = 4'd0;
          ptr_d   = gid_q + 2'd1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = 4'b0000;
        valid_d = 1'b0;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= 2'd0;
      cnt_q   <= 4'd0;
      gid_q   <= 2'd0;
      grant_q <= 4'b0000;
      valid_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gid_q   <= gid_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      armed_q <= armed_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = gid_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_rr_arbiter_4;

  localparam int HM = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       valid;

  int n_pass = 0;
  int n_total = 0;
  bit running = 1'b1;

  rr_arbiter_4 #(.HOLD_MAX(HM)) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .grant_id (grant_id),
    .valid    (valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: holder index (-1 = none), tenure, pointer, arm flag.
  int m_holder = -1;
  int m_gid = 0;
  int m_ten = 0;
  int m_ptr = 0;
  bit m_armed = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_holder = -1; m_gid = 0; m_ten = 0; m_ptr = 0; m_armed = 1'b0;
    end else if (!m_armed) begin
      m_armed = 1'b1;
    end else if (m_holder < 0) begin
      if (ena && req != 4'b0000) begin
        for (int k = 0; k < 4; k++) begin
          if (m_holder < 0 && req[(m_ptr + k) % 4]) m_holder = (m_ptr + k) % 4;
        end
        m_gid = m_holder;
        m_ten = 1;
      end
    end else begin
      if (done || !req[m_holder] || !ena || m_ten == HM) begin
        m_ptr = (m_holder + 1) % 4;
        m_holder = -1;
        m_ten = 0;
      end else begin
        m_ten++;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (running && !rst) begin
      check("model_valid", int'(valid), (m_holder >= 0) ? 1 : 0);
      check("model_grant", int'(grant), (m_holder >= 0) ? (1 << m_holder) : 0);
      check("model_grant_id", int'(grant_id), m_gid);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    // Reset and first grant two edges after deassert.
    cyc(); cyc();
    rst = 1'b0;
    check("reset_grant", int'(grant), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_gid", int'(grant_id), 0);
    ena = 1'b1; req = 4'b1010;
    cyc();
    check("arm_edge_no_grant", int'(valid), 0);
    cyc();
    check("first_grant", int'(grant), 4'b0010);
    check("first_gid", int'(grant_id), 1);
    done = 1'b1;
    cyc();
    check("done_release", int'(grant), 0);
    check("gid_retained", int'(grant_id), 1);
    done = 1'b0;
    cyc();
    check("ptr2_grant", int'(grant), 4'b1000);

    // Fairness with all requesters active.
    done = 1'b1; req = 4'b1111;
    cyc();
    check("fair_idle_0", int'(grant), 0);
    done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check($sformatf("fair_grant_%0d", i), int'(grant), 1 << (i % 4));
      done = 1'b1;
      cyc();
      check($sformatf("fair_idle_%0d", i + 1), int'(grant), 0);
      done = 1'b0;
    end

    // Tenure timeout with a single requester.
    req = 4'b0100;
    for (int i = 0; i < HM; i++) begin
      cyc();
      check($sformatf("hold_%0d", i), int'(grant), 4'b0100);
    end
    cyc();
    check("timeout_idle", int'(grant), 0);
    cyc();
    check("timeout_regrant", int'(grant), 4'b0100);

    // Requester drop: move holder to 0, then drop req[0] with req[3] pending.
    req = 4'b0001;
    cyc();
    check("drop2_idle", int'(grant), 0);
    cyc();
    check("grant0", int'(grant), 4'b0001);
    req = 4'b1000;
    cyc();
    check("drop0_idle", int'(grant), 0);
    cyc();
    check("grant3_after_drop", int'(grant), 4'b1000);

    // Disable during BUSY, then no grants while disabled.
    ena = 1'b0; req = 4'b1111;
    cyc();
    check("ena_release", int'(valid), 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check($sformatf("ena0_no_grant_%0d", i), int'(grant), 0);
    end

    // Asynchronous reset in the middle of a grant.
    ena = 1'b1; req = 4'b0100;
    cyc();
    check("pre_reset_grant", int'(grant), 4'b0100);
    #2 rst = 1'b1;
    #1;
    check("async_rst_grant", int'(grant), 0);
    check("async_rst_valid", int'(valid), 0);
    #1 rst = 1'b0;
    req = 4'b0110;
    cyc();
    check("post_rst_arm", int'(valid), 0);
    cyc();
    check("post_rst_grant", int'(grant), 4'b0010);

    // Randomized phase, checked by the per-cycle model comparison.
    for (int i = 0; i < 3000; i++) begin
      cyc();
      ena  = ($urandom_range(0, 19) != 0);
      done = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      if (i == 1500) begin
        #3 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end

    cyc();
    running = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
